antirrebote_entradas: RTL and testbench

- Conditions the raw board switches/push-buttons that drive the A and B inputs of the logic-gate block.
- Per input: 2-flop synchronizer, then a stability filter that accepts a new level only after it has held for CICLOS_ESTABLE consecutive cycles.
- Outputs clean levels plus one-cycle rise and fall pulses. The gate block consumes the clean levels directly.

---
 rtl/antirrebote_entradas.sv | 160 ++++++++++++++++
 tb/tb_antirrebote_entradas.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/antirrebote_entradas.sv
// Switch/push-button conditioner: 2-flop synchronizer plus per-bit stability filter with edge pulses.
// Optional activity counter output 'cambios' enabled by defining ANTIRREBOTE_CONTADOR_EN.
module antirrebote_entradas #(
    parameter int N_ENTRADAS     = 2,
    parameter int CICLOS_ESTABLE = 50000,
    parameter int ANCHO_CNT      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_ENTRADAS-1:0] ent,
    output logic [N_ENTRADAS-1:0] sal,
    output logic [N_ENTRADAS-1:0] flanco_sub,
    output logic [N_ENTRADAS-1:0] flanco_baj,
    output logic                  listo
`ifdef ANTIRREBOTE_CONTADOR_EN
    ,
    output logic [7:0]            cambios
`endif
);

    if (N_ENTRADAS < 1 || N_ENTRADAS > 16) begin : g_err_n
        $error("antirrebote_entradas: N_ENTRADAS must be in 1..16");
    end
    if (CICLOS_ESTABLE < 2) begin : g_err_ciclos
        $error("antirrebote_entradas: CICLOS_ESTABLE must be >= 2");
    end
    if (ANCHO_CNT < 1 || ANCHO_CNT > 62 || (64'd1 << ANCHO_CNT) <= 64'(CICLOS_ESTABLE)) begin : g_err_ancho
        $error("antirrebote_entradas: 2**ANCHO_CNT must exceed CICLOS_ESTABLE");
    end

    typedef enum logic [1:0] {
        EST_BAJO = 2'b00,
        VAL_ALTO = 2'b01,
        EST_ALTO = 2'b11,
        VAL_BAJO = 2'b10
    } estado_t;

    localparam logic [ANCHO_CNT-1:0] CNT_UNO   = ANCHO_CNT'(1);
    localparam logic [ANCHO_CNT-1:0] CNT_FIN   = ANCHO_CNT'(CICLOS_ESTABLE - 1);
    localparam int                   ANCHO_LST = ANCHO_CNT + 1;
    localparam logic [ANCHO_LST-1:0] LISTO_UNO = ANCHO_LST'(1);
    localparam logic [ANCHO_LST-1:0] LISTO_FIN = ANCHO_LST'(CICLOS_ESTABLE + 1);

    logic [N_ENTRADAS-1:0] sync_p0;
    logic [N_ENTRADAS-1:0] sync_p1;
    estado_t               est   [N_ENTRADAS];
    estado_t               est_n [N_ENTRADAS];
    logic [ANCHO_CNT-1:0]  cnt   [N_ENTRADAS];
    logic [ANCHO_CNT-1:0]  cnt_n [N_ENTRADAS];
    logic [N_ENTRADAS-1:0] nivel;
    logic [ANCHO_LST-1:0]  cnt_listo;

    // Stage p0/p1: two-flop synchronizer on the raw asynchronous levels
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= ent;
            sync_p1 <= sync_p0;
        end
    end

    // Stability filter: one FSM plus counter per bit
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_ENTRADAS; i++) begin
            if (rst) begin
                est[i] <= EST_BAJO;
                cnt[i] <= '0;
            end else begin
                est[i] <= est_n[i];
                cnt[i] <= cnt_n[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_ENTRADAS; i++) begin
            est_n[i] = est[i];
            cnt_n[i] = '0;
            case (est[i])
                EST_BAJO: begin
                    if (sync_p1[i]) begin
                        est_n[i] = VAL_ALTO;
                        cnt_n[i] = CNT_UNO;
                    end
                end
                VAL_ALTO: begin
                    if (!sync_p1[i])            est_n[i] = EST_BAJO;
                    else if (cnt[i] == CNT_FIN) est_n[i] = EST_ALTO;
                    else                        cnt_n[i] = cnt[i] + CNT_UNO;
                end
                EST_ALTO: begin
                    if (!sync_p1[i]) begin
                        est_n[i] = VAL_BAJO;
                        cnt_n[i] = CNT_UNO;
                    end
                end
                VAL_BAJO: begin
                    if (sync_p1[i])             est_n[i] = EST_ALTO;
                    else if (cnt[i] == CNT_FIN) est_n[i] = EST_BAJO;
                    else                        cnt_n[i] = cnt[i] + CNT_UNO;
                end
                default: est_n[i] = EST_BAJO;
            endcase
        end
    end

    always_comb begin
        nivel = '0;
        for (int i = 0; i < N_ENTRADAS; i++) begin
            nivel[i] = (est[i] == EST_ALTO) || (est[i] == VAL_BAJO);
        end
    end

    // Stage p2: registered outputs; pulses mark the cycle 'sal' takes the accepted level
    always_ff @(posedge clk) begin
        if (rst) begin
            sal        <= '0;
            flanco_sub <= '0;
            flanco_baj <= '0;
        end else begin
            sal        <= nivel;
            flanco_sub <= nivel & ~sal;
            flanco_baj <= ~nivel & sal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_listo <= '0;
            listo     <= 1'b0;
        end else if (!listo) begin
            if (cnt_listo == LISTO_FIN) listo <= 1'b1;
            else                        cnt_listo <= cnt_listo + LISTO_UNO;
        end
    end

`ifdef ANTIRREBOTE_CONTADOR_EN
    function automatic logic [4:0] cuenta_unos(input logic [N_ENTRADAS-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < N_ENTRADAS; i++) n = n + {4'b0000, v[i]};
        return n;
    endfunction

    function automatic logic [7:0] suma_sat(input logic [7:0] a, input logic [4:0] b);
        logic [8:0] t;
        t = {1'b0, a} + {4'b0000, b};
        return (t > 9'd255) ? 8'hff : t[7:0];
    endfunction

    // Counts the same edges that the pulse register emits on this clock
    always_ff @(posedge clk) begin
        if (rst) cambios <= '0;
        else     cambios <= suma_sat(cambios, cuenta_unos(nivel ^ sal));
    end
`endif

endmodule

// File: tb/tb_antirrebote_entradas.sv
// Scoreboard bench for antirrebote_entradas (N_ENTRADAS=2, CICLOS_ESTABLE=4); run-length reference model.
module tb_antirrebote_entradas;
    localparam int C = 4;

    logic       clk;
    logic       rst;
    logic [1:0] ent;
    logic [1:0] sal, flanco_sub, flanco_baj;
    logic       listo;
`ifdef ANTIRREBOTE_CONTADOR_EN
    logic [7:0] cambios;
`endif

    antirrebote_entradas #(.N_ENTRADAS(2), .CICLOS_ESTABLE(C), .ANCHO_CNT(8)) dut (
        .clk(clk), .rst(rst), .ent(ent), .sal(sal),
        .flanco_sub(flanco_sub), .flanco_baj(flanco_baj), .listo(listo)
`ifdef ANTIRREBOTE_CONTADOR_EN
        , .cambios(cambios)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] sub;
        logic [1:0] baj;
    } pulso_t;

    pulso_t     sb[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    bit         started = 0;
    logic [1:0] q1 = '0, q2 = '0, lvl = '0, m_sal = '0;
    int         run[2];
    int         n_listo = 0;
    logic       m_listo = 1'b0;
    int         m_cam = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic ciclos(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: a bit's accepted level flips once the synchronized input has
    // differed from it for C consecutive samples; 'sal' follows one clock later.
    task automatic modelo();
        logic [1:0] chg;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                q1 = '0; q2 = '0; lvl = '0; m_sal = '0;
                run[0] = 0; run[1] = 0;
                n_listo = 0; m_listo = 1'b0; m_cam = 0;
            end else begin
                chg = lvl ^ m_sal;
                if (chg != 2'b00) begin
                    sb.push_back('{cyc, chg & lvl, chg & ~lvl});
                    m_cam = m_cam + $countones(chg);
                    if (m_cam > 255) m_cam = 255;
                end
                m_sal = lvl;
                for (int i = 0; i < 2; i++) begin
                    if (q2[i] != lvl[i]) run[i]++;
                    else run[i] = 0;
                    if (run[i] == C) begin
                        lvl[i] = ~lvl[i];
                        run[i] = 0;
                    end
                end
                q2 = q1;
                q1 = ent;
                n_listo++;
                m_listo = (n_listo >= C + 2);
            end
            started = 1;
        end
    endtask

    task automatic monitor();
        pulso_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                chk("sal", 32'(sal), 32'(m_sal));
                chk("listo", 32'(listo), 32'(m_listo));
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    chk("flanco_sub", 32'(flanco_sub), 32'(e.sub));
                    chk("flanco_baj", 32'(flanco_baj), 32'(e.baj));
                end else begin
                    chk("pulso_inesperado", 32'({flanco_sub, flanco_baj}), 32'd0);
                end
`ifdef ANTIRREBOTE_CONTADOR_EN
                chk("cambios", 32'(cambios), 32'(m_cam));
`endif
            end
        end
    endtask

    // Counts falling edges until cond becomes true on bit b of sal (or listo when b<0); 21 = timeout.
    task automatic espera(input int b, input logic v, output int k);
        k = 21;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if ((b < 0) ? (listo == v) : (sal[b] == v)) begin
                k = j;
                break;
            end
        end
    endtask

    int k;

    initial begin
        rst = 1'b1;
        ent = 2'b00;
        fork
            modelo();
            monitor();
        join_none

        // Reset hold with both switches closed
        @(negedge clk);
        ent = 2'b11;
        ciclos(3);
        chk("reset_sal", 32'(sal), 32'd0);
        chk("reset_listo", 32'(listo), 32'd0);
        rst = 1'b0;
        espera(-1, 1'b1, k);
        chk("listo_latencia", k, C + 2);
        ciclos(6);
        chk("sal_tras_reset", 32'(sal), 32'd3);

        // Return to 00, then clean rise on bit 0: edge t is the first negedge-wait (k=1), sal at t+2+C
        ent = 2'b00;
        ciclos(12);
        ent = 2'b01;
        espera(0, 1'b1, k);
        chk("subida_latencia", k, C + 3);
        chk("subida_pulso", 32'(flanco_sub), 32'd1);
        @(negedge clk);
        chk("subida_pulso_fin", 32'(flanco_sub), 32'd0);
        ciclos(4);

        // Bounce rejected on bit 1
        for (int j = 0; j < 5; j++) begin
            ent = {j[0], 1'b1};
            ciclos(2);
        end
        ent = 2'b01;
        ciclos(10);
        chk("rebote_sal1", 32'(sal[1]), 32'd0);

        // Bounce, then settle high on bit 1
        ent = 2'b11; ciclos(1);
        ent = 2'b01; ciclos(1);
        ent = 2'b11;
        espera(1, 1'b1, k);
        chk("asentado_latencia", k, C + 3);
        ciclos(4);

        // Simultaneous fall on both bits
        ent = 2'b00;
        espera(0, 1'b0, k);
        chk("bajada_doble_baj", 32'(flanco_baj), 32'd3);
        chk("bajada_doble_sal", 32'(sal), 32'd0);
        ent = 2'b11;
        ciclos(12);

        // Drop again, reset lands inside the validation window
        ent = 2'b00;
        ciclos(3);
        rst = 1'b1;
        ciclos(2);
        chk("reset_medio_sal", 32'(sal), 32'd0);
        chk("reset_medio_listo", 32'(listo), 32'd0);
        rst = 1'b0;
        ciclos(12);

        // Randomized bouncing with occasional resets
        for (int s = 0; s < 300; s++) begin
            ent = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                ciclos($urandom_range(1, 3));
                rst = 1'b0;
            end
            ciclos($urandom_range(1, 9));
        end
        ciclos(10);

`ifdef ANTIRREBOTE_CONTADOR_EN
        ent = 2'b00;
        rst = 1'b1;
        ciclos(2);
        rst = 1'b0;
        ciclos(8);
        for (int j = 0; j < 10; j++) begin
            ent = {1'b0, ~ent[0]};
            ciclos(C + 4);
        end
        chk("cambios_diez", 32'(cambios), 32'd10);
        ent = 2'b11;
        ciclos(C + 6);
        chk("cambios_doble", 32'(cambios), 32'd12);
        for (int j = 0; j < 160; j++) begin
            ent = ~ent;
            ciclos(C + 2);
        end
        ciclos(8);
        chk("cambios_saturado", 32'(cambios), 32'd255);
`endif

        ciclos(4);
        chk("scoreboard_vacio", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
